// File: rtl/usb_auth_req_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : usb_auth_req_initiator
//  Description : Controller-side initiator of the USB Type-C authentication
//                exchange. Debounces cable attach/orientation from CC1/CC2,
//                issues one authentication request to the host, runs the
//                request/accept/ack handshake with timeout and retry, then
//                captures the host response and checks its header.
//  Ports       : clk, reset             - clock, synchronous active-high reset
//                CC1, CC2               - configuration channel levels
//                resp_req_in            - host ready (1) / request accepted (0)
//                Ack_out_resp           - host response valid strobe
//                auth_msg_resp_in       - response message from host
//                resp_req_out           - request strobe to host
//                auth_msg_resp_out      - request message to host
//                attached, orient       - debounced attach state, 1 = CC1 active
//                resp_valid, resp_msg   - good-response pulse, captured response
//                err, err_code          - sticky error and its cause
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_auth_req_initiator #(
    parameter int         MSG_LEN         = 2079,
    parameter logic [7:0] PROTO_VER       = 8'h01,
    parameter logic [7:0] REQ_TYPE        = 8'h81,
    parameter logic [7:0] RESP_TYPE       = 8'h09,
    parameter int         DEBOUNCE_CYCLES = 8,
    parameter int         TIMEOUT_CYCLES  = 64,
    parameter int         MAX_RETRIES     = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               CC1,
    input  logic               CC2,
    input  logic               resp_req_in,
    input  logic               Ack_out_resp,
    input  logic [MSG_LEN-1:0] auth_msg_resp_in,
    output logic               resp_req_out,
    output logic [MSG_LEN-1:0] auth_msg_resp_out,
    output logic               attached,
    output logic               orient,
    output logic               resp_valid,
    output logic [MSG_LEN-1:0] resp_msg,
    output logic               err,
    output logic [1:0]         err_code
);

    localparam int c_DB_W  = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_TMO_W = (TIMEOUT_CYCLES < 2)  ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_RTY_W = (MAX_RETRIES < 1)     ? 1 : $clog2(MAX_RETRIES + 1);

    localparam logic [c_DB_W-1:0]  c_DB_LAST  = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_DB_W-1:0]  c_DB_ONE   = c_DB_W'(1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TMO_W-1:0] c_TMO_ONE  = c_TMO_W'(1);
    localparam logic [c_RTY_W-1:0] c_RTY_MAX  = c_RTY_W'(MAX_RETRIES);
    localparam logic [c_RTY_W-1:0] c_RTY_ONE  = c_RTY_W'(1);

    localparam logic [1:0] c_ERR_TMO  = 2'd1;
    localparam logic [1:0] c_ERR_VER  = 2'd2;
    localparam logic [1:0] c_ERR_TYPE = 2'd3;

    localparam logic [MSG_LEN-1:0] c_REQ_MSG =
        {PROTO_VER, REQ_TYPE, 16'h0000, {(MSG_LEN-32){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SEND_REQ = 3'd1,
        S_WAIT_ACK = 3'd2,
        S_CHECK    = 3'd3,
        S_DONE     = 3'd4,
        S_ERROR    = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic                 r_prev_attach;
    logic                 r_prev_cc1;
    logic [c_DB_W-1:0]    r_db_cnt;
    logic [c_DB_W-1:0]    r_det_cnt;
    logic [c_TMO_W-1:0]   r_tmo;
    logic [c_RTY_W-1:0]   r_retries;

    logic                 r_resp_req;
    logic [MSG_LEN-1:0]   r_msg_out;
    logic                 r_attached;
    logic                 r_orient;
    logic                 r_resp_valid;
    logic [MSG_LEN-1:0]   r_resp_msg;
    logic                 r_err;
    logic [1:0]           r_err_code;

    logic                 w_cc_attach;
    logic                 w_cc_eq;
    logic                 w_cc_stable;
    logic [c_DB_W-1:0]    w_db_next;
    logic                 w_det_hit;
    logic                 w_tmo_hit;
    logic [7:0]           w_rsp_ver;
    logic [7:0]           w_rsp_type;

    logic                 w_attach_evt;
    logic                 w_detach_evt;
    logic                 w_req_next;
    logic                 w_capture;
    logic                 w_valid_next;
    logic                 w_err_set;
    logic [1:0]           w_err_code;
    logic                 w_retry;

    assign w_cc_attach = CC1 ^ CC2;
    assign w_cc_eq     = ~w_cc_attach;
    // Stable means attached now, attached last cycle, and same orientation.
    assign w_cc_stable = w_cc_attach & r_prev_attach & (CC1 == r_prev_cc1);
    assign w_db_next   = w_cc_stable ? (r_db_cnt + c_DB_ONE) : '0;
    // r_det_cnt holds the number of prior consecutive equal samples, so this
    // fires on the DEBOUNCE_CYCLES-th one.
    assign w_det_hit   = (r_state != S_IDLE) && w_cc_eq && (r_det_cnt == c_DB_LAST);
    assign w_tmo_hit   = ((r_state == S_SEND_REQ) || (r_state == S_WAIT_ACK)) &&
                         (r_tmo == c_TMO_LAST);
    assign w_rsp_ver   = r_resp_msg[MSG_LEN-1 -: 8];
    assign w_rsp_type  = r_resp_msg[MSG_LEN-9 -: 8];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_attach_evt = 1'b0;
        w_detach_evt = 1'b0;
        w_req_next   = 1'b0;
        w_capture    = 1'b0;
        w_valid_next = 1'b0;
        w_err_set    = 1'b0;
        w_err_code   = 2'd0;
        w_retry      = 1'b0;

        if (r_state == S_IDLE) begin
            if (w_cc_attach && (w_db_next == c_DB_LAST)) begin
                w_attach_evt = 1'b1;
                w_state_next = S_SEND_REQ;
            end
        end else if (w_det_hit) begin
            w_detach_evt = 1'b1;
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_SEND_REQ: begin
                    // Acceptance only counts once the request is visible.
                    if (r_resp_req && !resp_req_in) begin
                        w_state_next = S_WAIT_ACK;
                    end else if (w_tmo_hit) begin
                        if (r_retries < c_RTY_MAX) begin
                            // Staying in SEND_REQ with the strobe low for
                            // this cycle yields the one-cycle gap.
                            w_retry = 1'b1;
                        end else begin
                            w_err_set    = 1'b1;
                            w_err_code   = c_ERR_TMO;
                            w_state_next = S_ERROR;
                        end
                    end else begin
                        w_req_next = 1'b1;
                    end
                end
                S_WAIT_ACK: begin
                    if (Ack_out_resp) begin
                        w_capture    = 1'b1;
                        w_state_next = S_CHECK;
                    end else if (w_tmo_hit) begin
                        if (r_retries < c_RTY_MAX) begin
                            w_retry      = 1'b1;
                            w_state_next = S_SEND_REQ;
                        end else begin
                            w_err_set    = 1'b1;
                            w_err_code   = c_ERR_TMO;
                            w_state_next = S_ERROR;
                        end
                    end
                end
                S_CHECK: begin
                    if (w_rsp_ver != PROTO_VER) begin
                        w_err_set    = 1'b1;
                        w_err_code   = c_ERR_VER;
                        w_state_next = S_ERROR;
                    end else if (w_rsp_type != RESP_TYPE) begin
                        w_err_set    = 1'b1;
                        w_err_code   = c_ERR_TYPE;
                        w_state_next = S_ERROR;
                    end else begin
                        w_valid_next = 1'b1;
                        w_state_next = S_DONE;
                    end
                end
                default: begin
                    // DONE and ERROR hold until detach.
                    w_state_next = r_state;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_attach <= 1'b0;
            r_prev_cc1    <= 1'b0;
            r_db_cnt      <= '0;
            r_det_cnt     <= '0;
            r_tmo         <= '0;
            r_retries     <= '0;
            r_resp_req    <= 1'b0;
            r_msg_out     <= '0;
            r_attached    <= 1'b0;
            r_orient      <= 1'b0;
            r_resp_valid  <= 1'b0;
            r_resp_msg    <= '0;
            r_err         <= 1'b0;
            r_err_code    <= 2'd0;
        end else begin
            r_prev_attach <= w_cc_attach;
            r_prev_cc1    <= CC1;

            r_db_cnt  <= ((r_state == S_IDLE) && !w_attach_evt) ? w_db_next : '0;
            r_det_cnt <= ((r_state != S_IDLE) && !w_detach_evt && w_cc_eq) ?
                         (r_det_cnt + c_DB_ONE) : '0;

            if ((w_state_next != r_state) || w_retry) begin
                r_tmo <= '0;
            end else if ((r_state == S_SEND_REQ) || (r_state == S_WAIT_ACK)) begin
                r_tmo <= r_tmo + c_TMO_ONE;
            end else begin
                r_tmo <= '0;
            end

            if (w_attach_evt || w_detach_evt) begin
                r_retries <= '0;
            end else if (w_retry) begin
                r_retries <= r_retries + c_RTY_ONE;
            end

            if (w_attach_evt) begin
                r_attached <= 1'b1;
                r_orient   <= CC1;
            end else if (w_detach_evt) begin
                r_attached <= 1'b0;
            end

            r_resp_req <= w_req_next;
            if (w_req_next) begin
                r_msg_out <= c_REQ_MSG;
            end

            if (w_capture) begin
                r_resp_msg <= auth_msg_resp_in;
            end
            r_resp_valid <= w_valid_next;

            if (w_detach_evt) begin
                r_err      <= 1'b0;
                r_err_code <= 2'd0;
            end else if (w_err_set) begin
                r_err      <= 1'b1;
                r_err_code <= w_err_code;
            end
        end
    end

    assign resp_req_out      = r_resp_req;
    assign auth_msg_resp_out = r_msg_out;
    assign attached          = r_attached;
    assign orient            = r_orient;
    assign resp_valid        = r_resp_valid;
    assign resp_msg          = r_resp_msg;
    assign err               = r_err;
    assign err_code          = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_usb_auth_req_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_usb_auth_req_initiator
//  Description : Table-driven bench for usb_auth_req_initiator, plus directed
//                sequences for timeout/retry and reset during WAIT_ACK.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_auth_req_initiator;

    localparam int          MSG_LEN = 2079;
    localparam logic [31:0] c_IDLE_HDR = 32'hDEADBEEF;

    logic               clk = 1'b0;
    logic               reset;
    logic               CC1, CC2, resp_req_in, Ack_out_resp;
    logic [MSG_LEN-1:0] auth_msg_resp_in;
    logic               resp_req_out;
    logic [MSG_LEN-1:0] auth_msg_resp_out;
    logic               attached, orient, resp_valid, err;
    logic [MSG_LEN-1:0] resp_msg;
    logic [1:0]         err_code;

    usb_auth_req_initiator dut (
        .clk               (clk),
        .reset             (reset),
        .CC1               (CC1),
        .CC2               (CC2),
        .resp_req_in       (resp_req_in),
        .Ack_out_resp      (Ack_out_resp),
        .auth_msg_resp_in  (auth_msg_resp_in),
        .resp_req_out      (resp_req_out),
        .auth_msg_resp_out (auth_msg_resp_out),
        .attached          (attached),
        .orient            (orient),
        .resp_valid        (resp_valid),
        .resp_msg          (resp_msg),
        .err               (err),
        .err_code          (err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          c1, c2, rri, ack;
        logic [31:0] hdr;
        bit          att, rro, val, e;
        logic [1:0]  code;
        bit          cm;   // compare resp_msg against the expected capture
    } vec_t;

    vec_t               vecs[$];
    int                 n_tests = 0;
    int                 n_fail  = 0;
    logic [MSG_LEN-1:0] payload, exp_msg, req_msg, zero_msg;

    function automatic logic [MSG_LEN-1:0] mk(input logic [31:0] hdr);
        logic [MSG_LEN-1:0] m;
        m = payload;
        m[MSG_LEN-1 -: 32] = hdr;
        return m;
    endfunction

    function automatic void add(input bit c1, input bit c2, input bit rri, input bit ack,
                                input logic [31:0] hdr, input bit att, input bit rro,
                                input bit val, input bit e, input logic [1:0] code,
                                input bit cm, input int n);
        vec_t v;
        v.c1 = c1; v.c2 = c2; v.rri = rri; v.ack = ack; v.hdr = hdr;
        v.att = att; v.rro = rro; v.val = val; v.e = e; v.code = code; v.cm = cm;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    // 8 stable samples from IDLE: attached on the 8th edge.
    function automatic void attach_seq(input bit c1, input bit c2);
        add(c1, c2, 1, 0, c_IDLE_HDR, 0, 0, 0, 0, 2'd0, 1, 7);
        add(c1, c2, 1, 0, c_IDLE_HDR, 1, 0, 0, 0, 2'd0, 1, 1);
    endfunction

    // Request 3 cycles, accept, wait, ack, check, then hold.
    function automatic void hs_seq(input bit c1, input bit c2, input logic [31:0] hdr,
                                   input bit ok, input logic [1:0] code);
        add(c1, c2, 1, 0, c_IDLE_HDR, 1, 1, 0, 0, 2'd0, 0, 3);
        add(c1, c2, 0, 0, c_IDLE_HDR, 1, 0, 0, 0, 2'd0, 0, 2);
        add(c1, c2, 0, 1, hdr,        1, 0, 0, 0, 2'd0, 1, 1);
        add(c1, c2, 1, 0, c_IDLE_HDR, 1, 0, ok, !ok, code, 1, 1);
        add(c1, c2, 1, 0, c_IDLE_HDR, 1, 0, 0, !ok, code, 1, 3);
    endfunction

    function automatic void det_seq(input bit c, input bit e, input logic [1:0] code);
        add(c, c, 1, 0, c_IDLE_HDR, 1, 0, 0, e, code, 1, 7);
        add(c, c, 1, 0, c_IDLE_HDR, 0, 0, 0, 0, 2'd0, 1, 1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic chk_msg(input string name, input logic [MSG_LEN-1:0] act,
                           input logic [MSG_LEN-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got hdr %h low %h required hdr %h low %h", name,
                     act[MSG_LEN-1 -: 32], act[79:0], req[MSG_LEN-1 -: 32], req[79:0]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  got, mism, rises;
        bit  prev, exp_rro;

        payload = '0;
        payload[75:0] = 76'h5165616516161691681;
        req_msg = '0;
        req_msg[MSG_LEN-1 -: 32] = 32'h01810000;
        zero_msg = '0;
        exp_msg  = '0;

        // Scenario table
        attach_seq(1, 0);
        hs_seq(1, 0, 32'h01090100, 1, 2'd0);
        det_seq(1, 0, 2'd0);
        add(1, 0, 1, 0, c_IDLE_HDR, 0, 0, 0, 0, 2'd0, 1, 3);   // 3-cycle glitch
        add(0, 0, 1, 0, c_IDLE_HDR, 0, 0, 0, 0, 2'd0, 1, 5);
        attach_seq(0, 1);
        hs_seq(0, 1, 32'h02090100, 0, 2'd2);
        det_seq(0, 1, 2'd2);
        attach_seq(1, 0);
        hs_seq(1, 0, 32'h01050100, 0, 2'd3);
        det_seq(0, 1, 2'd3);
        attach_seq(1, 0);
        hs_seq(1, 0, 32'h02050100, 0, 2'd2);
        det_seq(1, 1, 2'd2);

        // Reset
        reset = 1'b1; CC1 = 1'b0; CC2 = 1'b0; resp_req_in = 1'b1; Ack_out_resp = 1'b0;
        auth_msg_resp_in = mk(c_IDLE_HDR);
        repeat (4) step();
        chk("rst.attached", 32'(attached), 0);
        chk("rst.resp_req_out", 32'(resp_req_out), 0);
        chk("rst.resp_valid", 32'(resp_valid), 0);
        chk("rst.err", 32'(err), 0);
        chk("rst.err_code", 32'(err_code), 0);
        chk("rst.orient", 32'(orient), 0);
        chk_msg("rst.resp_msg", resp_msg, zero_msg);
        chk_msg("rst.req_msg", auth_msg_resp_out, zero_msg);
        reset = 1'b0;

        foreach (vecs[i]) begin
            CC1 = vecs[i].c1; CC2 = vecs[i].c2;
            resp_req_in = vecs[i].rri; Ack_out_resp = vecs[i].ack;
            auth_msg_resp_in = mk(vecs[i].hdr);
            if (vecs[i].ack) exp_msg = mk(vecs[i].hdr);
            step();
            chk($sformatf("v%0d.attached", i), 32'(attached), 32'(vecs[i].att));
            chk($sformatf("v%0d.resp_req_out", i), 32'(resp_req_out), 32'(vecs[i].rro));
            chk($sformatf("v%0d.resp_valid", i), 32'(resp_valid), 32'(vecs[i].val));
            chk($sformatf("v%0d.err", i), 32'(err), 32'(vecs[i].e));
            chk($sformatf("v%0d.err_code", i), 32'(err_code), 32'(vecs[i].code));
            if (vecs[i].att && (vecs[i].c1 != vecs[i].c2))
                chk($sformatf("v%0d.orient", i), 32'(orient), 32'(vecs[i].c1));
            if (vecs[i].rro)
                chk_msg($sformatf("v%0d.req_msg", i), auth_msg_resp_out, req_msg);
            if (vecs[i].cm)
                chk_msg($sformatf("v%0d.resp_msg", i), resp_msg, exp_msg);
        end

        // Timeout with two retries: host never accepts
        CC1 = 1'b1; CC2 = 1'b0; resp_req_in = 1'b1; Ack_out_resp = 1'b0;
        got = -1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (attached) begin
                got = i;
                break;
            end
        end
        chk("tmo.attach_latency", 32'(got + 1), 8);
        mism = 0; rises = 0; prev = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            step();
            exp_rro = (k < 192) && ((k % 64) != 0);
            if (resp_req_out !== exp_rro) mism++;
            if (resp_req_out && !prev) rises++;
            prev = resp_req_out;
        end
        chk("tmo.rro_pattern_bad_cycles", 32'(mism), 0);
        chk("tmo.request_count", 32'(rises), 3);
        chk("tmo.err", 32'(err), 1);
        chk("tmo.err_code", 32'(err_code), 1);
        chk("tmo.resp_req_out", 32'(resp_req_out), 0);

        // Detach from ERROR, then reset in WAIT_ACK with Ack high
        CC1 = 1'b0; CC2 = 1'b0;
        repeat (8) step();
        chk("det2.attached", 32'(attached), 0);
        chk("det2.err", 32'(err), 0);
        chk("det2.err_code", 32'(err_code), 0);
        CC1 = 1'b1;
        repeat (8) step();
        chk("rmid.attached", 32'(attached), 1);
        repeat (2) step();
        chk("rmid.resp_req_out", 32'(resp_req_out), 1);
        resp_req_in = 1'b0;
        step();
        chk("rmid.accept", 32'(resp_req_out), 0);
        reset = 1'b1; Ack_out_resp = 1'b1; auth_msg_resp_in = mk(32'h01090100);
        step();
        chk("rmid.attached", 32'(attached), 0);
        chk("rmid.err", 32'(err), 0);
        chk("rmid.resp_valid", 32'(resp_valid), 0);
        chk_msg("rmid.resp_msg", resp_msg, zero_msg);
        chk_msg("rmid.req_msg", auth_msg_resp_out, zero_msg);
        reset = 1'b0; Ack_out_resp = 1'b0; resp_req_in = 1'b1;
        step();
        step();
        chk("rmid.post_valid", 32'(resp_valid), 0);
        chk("rmid.post_attached", 32'(attached), 0);
        chk("rmid.post_rro", 32'(resp_req_out), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/usb_auth_req_initiator.md
Name: usb_auth_req_initiator

Overview:
- Controller-side initiator of the USB Type-C authentication exchange.
- Detects cable attach and orientation from CC1/CC2, debounces it, then issues one authentication request message to the USB host.
- Completes the request/accept/ack handshake, captures the host's response message and checks its header.
- Sits between the CC front end and the authentication engine; it is the counterpart of the host responder.

Parameters:
MSG_LEN, 2079, message width in bits; bits [MSG_LEN-1:MSG_LEN-32] form the 4-byte header {ProtocolVersion, MessageType, Param1, Param2}.
PROTO_VER, 8'h01, required ProtocolVersion in both directions.
REQ_TYPE, 8'h81, MessageType placed in the outgoing request.
RESP_TYPE, 8'h09, MessageType expected in the response.
DEBOUNCE_CYCLES, 8, consecutive stable cycles needed to declare attach or detach.
TIMEOUT_CYCLES, 64, maximum cycles spent waiting in any handshake state.
MAX_RETRIES, 2, request re-issues allowed after a timeout.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
CC1  input  1  configuration channel 1 level.
CC2  input  1  configuration channel 2 level.
resp_req_in  input  1  host response-pending flag; high = host idle/ready, low = host has accepted the request.
Ack_out_resp  input  1  host asserts when auth_msg_resp_in holds a valid response.
auth_msg_resp_in  input  MSG_LEN  response message from host.
resp_req_out  output  1  request strobe to host; held until accepted.
auth_msg_resp_out  output  MSG_LEN  request message to host.
attached  output  1  debounced attach indication.
orient  output  1  1 = CC1 active, 0 = CC2 active; valid while attached.
resp_valid  output  1  one-cycle pulse: response captured and header OK.
resp_msg  output  MSG_LEN  last captured response; held until next capture.
err  output  1  sticky error; cleared on detach or reset.
err_code  output  2  0 none, 1 timeout/retries exhausted, 2 bad ProtocolVersion, 3 bad MessageType.

Behaviour:
- Reset (sync, high):
  - state = IDLE; all outputs 0, including resp_msg and auth_msg_resp_out.
  - Debounce, timeout and retry counters = 0.
  - Reset dominates every other event in the same cycle.
- Attach condition: CC1 ^ CC2 = 1. Candidate orientation = CC1.
- IDLE:
  - Counter increments while the attach condition holds and the candidate orientation is unchanged.
  - Any change (including a change to CC1 = CC2) clears the counter.
  - When the counter reaches DEBOUNCE_CYCLES-1: register orient, set attached = 1, go to SEND_REQ.
- Detach: CC1 = CC2 for DEBOUNCE_CYCLES consecutive cycles in any non-IDLE state:
  - go to IDLE; clear attached, resp_req_out, err, err_code.
  - resp_msg is kept.
  - Detach has priority over handshake events in the same cycle.
- SEND_REQ:
  - auth_msg_resp_out = {PROTO_VER, REQ_TYPE, 8'h00, 8'h00, zeros}; resp_req_out = 1 (registered, one cycle after entry).
  - Sample resp_req_in == 0 (host accepted) -> WAIT_ACK; resp_req_out drops the next cycle.
  - Timeout counter runs from state entry.
- WAIT_ACK:
  - Wait for Ack_out_resp == 1; capture auth_msg_resp_in into resp_msg that same edge; go to CHECK.
  - If Ack_out_resp is already high on entry, capture on the first WAIT_ACK cycle.
- CHECK (one cycle):
  - Version mismatch -> err_code 2.
  - Else type mismatch -> err_code 3.
  - Else resp_valid pulses for exactly 1 cycle -> DONE.
  - Both mismatching reports 2.
  - Errors set err and go to ERROR.
- Latency: Ack sampled at edge N -> resp_valid high during cycle N+1 -> N+2.
- Timeout:
  - Counter reaches TIMEOUT_CYCLES in SEND_REQ or WAIT_ACK and retries < MAX_RETRIES: retries++, deassert resp_req_out for one cycle, re-enter SEND_REQ.
  - Otherwise err_code 1 -> ERROR.
  - The timeout counter clears on every state change.
- DONE and ERROR:
  - Hold until detach; no new request while attached.
  - resp_req_out = 0; auth_msg_resp_out keeps its last value.

Test Plan:
1. Reset high 4 cycles, CC1=CC2=0 -> all outputs 0, state IDLE, no resp_req_out.
2. CC1=1, CC2=0 stable 8 cycles -> attached=1, orient=1. resp_req_out high the next cycle with header 01_81_00_00. Host drops resp_req_in 3 cycles later -> resp_req_out low the following cycle.
3. Host asserts Ack_out_resp with header 01_09_01_00 and payload 'h5165616516161691681 -> resp_msg equals input; resp_valid one-cycle pulse 1 cycle after capture; err=0.
4. Response header 02_09_01_00 -> err=1, err_code=2, no resp_valid. Header 01_05_01_00 -> err_code=3.
5. Host never drops resp_req_in -> resp_req_out re-issued twice, each after a 1-cycle gap. After the third 64-cycle timeout: err_code=1, resp_req_out=0.
6. CC1 glitch of 3 cycles during IDLE -> no attach. After DONE, CC1=CC2=1 for 8 cycles -> attached=0, err cleared, resp_msg retained. Reset asserted mid-WAIT_ACK -> IDLE next edge, outputs 0.
